seq_match_ctrl: RTL and testbench

- Round controller for the memory game; the consumer end of the random number generator's Allow/Access/Output interface.
- Enables the generator and issues one-cycle Access requests. Captures each 4-bit value into a sequence buffer.
- Replays the buffer to the display path, then checks player key entries against it under a per-key timeout.
- Reports pass, fail or timeout to the top-level scoring logic.

---
 rtl/seq_match_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_seq_match_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_match_ctrl.sv
// Memory-game round controller: pulls a sequence from the random generator,
// replays it to the display path, then checks timed player key entries.
module seq_match_ctrl #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned DW      = 4,
    parameter int unsigned TIMEOUT = 20,
    parameter int unsigned TW      = 8
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           Start,
    input  logic [3:0]                     SeqLen,
    output logic                           RngAllow,
    output logic                           RngAccess,
    input  logic [DW-1:0]                  RngData,
    input  logic                           KeyValid,
    input  logic [DW-1:0]                  KeyData,
    output logic                           ShowValid,
    output logic [DW-1:0]                  ShowData,
    output logic                           Busy,
    output logic                           Pass,
    output logic                           Fail,
    output logic                           TimedOut,
    output logic [$clog2(MAX_LEN+1)-1:0]   MatchCount
);

    localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAP,
        SHOW,
        WAIT_KEY,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [LW-1:0]   len_q, len_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [LW-1:0]   mc_q, mc_d;
    logic            pass_q, pass_d;
    logic            fail_q, fail_d;
    logic            to_q, to_d;
    logic            allow_q, allow_d;
    logic            access_q, access_d;
    logic            showv_q, showv_d;
    logic [DW-1:0]   showd_q, showd_d;
    logic            busy_q, busy_d;
    logic [DW-1:0]   seq_q [MAX_LEN];
    logic            at_last;

    assign at_last = (32'(idx_q) + 32'd1 == 32'(len_q));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        timer_d  = timer_q;
        mc_d     = mc_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        to_d     = to_q;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    if (SeqLen == '0)
                        len_d = LW'(1);
                    else if (32'(SeqLen) > MAX_LEN)
                        len_d = LW'(MAX_LEN);
                    else
                        len_d = LW'(SeqLen);
                    idx_d   = '0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    to_d    = 1'b0;
                    mc_d    = '0;
                    state_d = REQ;
                end
            end
            REQ: state_d = CAP;
            CAP: begin
                if (at_last) begin
                    idx_d   = '0;
                    state_d = SHOW;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = REQ;
                end
            end
            SHOW: begin
                if (at_last) begin
                    idx_d   = '0;
                    timer_d = '0;
                    state_d = WAIT_KEY;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            WAIT_KEY: begin
                // A key on the expiry cycle takes priority over the timeout.
                if (KeyValid) begin
                    if (KeyData == seq_q[idx_q]) begin
                        mc_d    = mc_q + 1'b1;
                        timer_d = '0;
                        if (at_last) begin
                            pass_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        fail_d  = 1'b1;
                        state_d = DONE;
                    end
                end else if (timer_q >= TW'(TIMEOUT - 1)) begin
                    fail_d  = 1'b1;
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        allow_d  = (state_d == REQ) || (state_d == CAP);
        access_d = (state_d == REQ);
        busy_d   = (state_d == REQ) || (state_d == CAP) ||
                   (state_d == SHOW) || (state_d == WAIT_KEY);
        showv_d  = (state_d == SHOW);
        showd_d  = '0;
        if (showv_d) begin
            // Single-entry rounds replay the value being captured on this edge.
            if (state_q == CAP && idx_q == '0)
                showd_d = RngData;
            else
                showd_d = seq_q[idx_d];
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            timer_q  <= '0;
            mc_q     <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            to_q     <= 1'b0;
            allow_q  <= 1'b0;
            access_q <= 1'b0;
            showv_q  <= 1'b0;
            showd_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            timer_q  <= timer_d;
            mc_q     <= mc_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            to_q     <= to_d;
            allow_q  <= allow_d;
            access_q <= access_d;
            showv_q  <= showv_d;
            showd_q  <= showd_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (state_q == CAP)
            seq_q[idx_q] <= RngData;
    end

    assign RngAllow   = allow_q;
    assign RngAccess  = access_q;
    assign ShowValid  = showv_q;
    assign ShowData   = showd_q;
    assign Busy       = busy_q;
    assign Pass       = pass_q;
    assign Fail       = fail_q;
    assign TimedOut   = to_q;
    assign MatchCount = mc_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Randomized round-level bench for seq_match_ctrl with a transaction model of
// fill, replay, key matching and timeout.
module tb_seq_match_ctrl;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned DW      = 4;
    localparam int unsigned TIMEOUT = 20;
    localparam int unsigned TW      = 8;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Start;
    logic [3:0]    SeqLen;
    logic          RngAllow;
    logic          RngAccess;
    logic [DW-1:0] RngData;
    logic          KeyValid;
    logic [DW-1:0] KeyData;
    logic          ShowValid;
    logic [DW-1:0] ShowData;
    logic          Busy;
    logic          Pass;
    logic          Fail;
    logic          TimedOut;
    logic [3:0]    MatchCount;

    always #5 Clk = ~Clk;

    seq_match_ctrl #(
        .MAX_LEN (MAX_LEN),
        .DW      (DW),
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .SeqLen     (SeqLen),
        .RngAllow   (RngAllow),
        .RngAccess  (RngAccess),
        .RngData    (RngData),
        .KeyValid   (KeyValid),
        .KeyData    (KeyData),
        .ShowValid  (ShowValid),
        .ShowData   (ShowData),
        .Busy       (Busy),
        .Pass       (Pass),
        .Fail       (Fail),
        .TimedOut   (TimedOut),
        .MatchCount (MatchCount)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [3:0]  gv   [MAX_LEN];
    int unsigned kgap [MAX_LEN];
    bit          kok  [MAX_LEN];
    int unsigned nkeys;

    task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic int unsigned outs();
        return int'({RngAllow, RngAccess, ShowValid, ShowData, Busy,
                     Pass, Fail, TimedOut, MatchCount});
    endfunction

    function automatic int unsigned clamp_len(input int unsigned s);
        if (s == 0) return 1;
        if (s > MAX_LEN) return MAX_LEN;
        return s;
    endfunction

    // outcome: 0 running, 1 pass, 2 mismatch, 3 timeout
    task automatic run_round(input int unsigned seqlen, input bit fixed_vals,
                             input bit stray_start, input bit abort_rst);
        int unsigned len;
        int unsigned mc;
        int unsigned outcome;
        logic [3:0]  key;
        len     = clamp_len(seqlen);
        mc      = 0;
        outcome = 0;
        if (!fixed_vals)
            for (int i = 0; i < int'(MAX_LEN); i++) gv[i] = 4'($urandom_range(0, 15));

        Start  = 1'b1;
        SeqLen = 4'(seqlen);
        tick();
        Start  = 1'b0;
        check_eq("start_busy", Busy, 1);
        check_eq("start_mc_clr", MatchCount, 0);
        check_eq("start_pass_clr", Pass, 0);
        check_eq("start_fail_clr", Fail, 0);

        for (int unsigned i = 0; i < len; i++) begin
            check_eq("access_on", RngAccess, 1);
            check_eq("allow_req", RngAllow, 1);
            RngData = 4'($urandom);
            Start   = stray_start;
            SeqLen  = 4'($urandom);
            tick();
            check_eq("access_off", RngAccess, 0);
            check_eq("allow_cap", RngAllow, 1);
            RngData = gv[i];
            Start   = 1'b0;
            tick();
            RngData = 4'($urandom);
        end

        for (int unsigned i = 0; i < len; i++) begin
            check_eq("show_valid", ShowValid, 1);
            check_eq("show_data", ShowData, gv[i]);
            check_eq("allow_show", RngAllow, 0);
            Start = stray_start;
            tick();
            Start = 1'b0;
        end
        check_eq("show_end", ShowValid, 0);
        check_eq("show_data_zero", ShowData, 0);

        for (int unsigned k = 0; k < nkeys && outcome == 0; k++) begin
            if (abort_rst && k == 1) begin
                #3 Rst = 1'b1;
                #1 check_eq("rst_async_outs", outs(), 0);
                #2 Rst = 1'b0;
                return;
            end
            for (int unsigned t = 1; t <= kgap[k] && outcome == 0; t++) begin
                KeyValid = 1'b0;
                Start    = stray_start;
                tick();
                Start    = 1'b0;
                if (t == TIMEOUT) outcome = 3;
                check_eq("timeout_fail", Fail, (t == TIMEOUT) ? 1 : 0);
            end
            if (outcome == 0) begin
                key      = kok[k] ? gv[k] : (gv[k] ^ 4'($urandom_range(1, 15)));
                KeyValid = 1'b1;
                KeyData  = key;
                tick();
                KeyValid = 1'b0;
                if (key == gv[mc]) begin
                    mc++;
                    if (mc == len) outcome = 1;
                end else begin
                    outcome = 2;
                end
                check_eq("match_count", MatchCount, mc);
            end
        end

        for (int unsigned t = 1; t <= TIMEOUT && outcome == 0; t++) begin
            tick();
            if (t == TIMEOUT) outcome = 3;
            check_eq("timeout_fail", Fail, (t == TIMEOUT) ? 1 : 0);
        end

        check_eq("done_pass", Pass, (outcome == 1) ? 1 : 0);
        check_eq("done_fail", Fail, (outcome >= 2) ? 1 : 0);
        check_eq("done_timedout", TimedOut, (outcome == 3) ? 1 : 0);
        check_eq("done_mc", MatchCount, mc);
        check_eq("done_busy", Busy, 0);
        check_eq("done_allow", RngAllow, 0);

        KeyValid = 1'b1;
        KeyData  = (mc < len) ? gv[mc] : gv[0];
        tick();
        KeyValid = 1'b0;
        tick();
        check_eq("hold_mc", MatchCount, mc);
        check_eq("hold_pass", Pass, (outcome == 1) ? 1 : 0);
        check_eq("hold_fail", Fail, (outcome >= 2) ? 1 : 0);
        check_eq("hold_show", ShowValid, 0);
    endtask

    initial begin
        int unsigned r;
        Rst      = 1'b1;
        Start    = 1'b0;
        SeqLen   = '0;
        RngData  = '0;
        KeyValid = 1'b0;
        KeyData  = '0;
        tick();
        check_eq("reset_outs", outs(), 0);
        Rst = 1'b0;
        tick();
        check_eq("idle_outs", outs(), 0);

        gv[0] = 4'd5; gv[1] = 4'd9; gv[2] = 4'd2;
        nkeys = 3;
        for (int i = 0; i < 3; i++) begin kgap[i] = 3; kok[i] = 1'b1; end
        run_round(3, 1'b1, 1'b0, 1'b0);

        nkeys = 2;
        kgap[0] = 2; kok[0] = 1'b1;
        kgap[1] = 2; kok[1] = 1'b0;
        run_round(3, 1'b1, 1'b0, 1'b0);

        nkeys = 0;
        run_round(2, 1'b0, 1'b0, 1'b0);

        nkeys = 2;
        for (int i = 0; i < 2; i++) begin kgap[i] = TIMEOUT - 1; kok[i] = 1'b1; end
        run_round(2, 1'b0, 1'b0, 1'b0);

        nkeys = 1; kgap[0] = 0; kok[0] = 1'b1;
        run_round(0, 1'b0, 1'b1, 1'b0);
        nkeys = MAX_LEN;
        for (int i = 0; i < int'(MAX_LEN); i++) begin kgap[i] = 1; kok[i] = 1'b1; end
        run_round(12, 1'b0, 1'b1, 1'b0);

        nkeys = 3;
        for (int i = 0; i < 3; i++) begin kgap[i] = 2; kok[i] = 1'b1; end
        run_round(4, 1'b0, 1'b0, 1'b1);
        check_eq("post_rst_outs", outs(), 0);
        nkeys = 1; kgap[0] = 1; kok[0] = 1'b1;
        run_round(1, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int unsigned sl;
            sl    = $urandom_range(0, 15);
            nkeys = $urandom_range(0, clamp_len(sl));
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                r = $urandom_range(0, 9);
                if (r < 7)      kgap[i] = $urandom_range(0, 4);
                else if (r < 9) kgap[i] = TIMEOUT - 1;
                else            kgap[i] = TIMEOUT;
                kok[i] = ($urandom_range(0, 7) != 0);
            end
            run_round(sl, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
